// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, zero-register address and data/address types
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback bus into the register file and its scoreboard
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              busy_set;
  logic [ADDR_W-1:0] busy_addr;
  logic              busy1;
  logic              busy2;
  logic [31:0]       wr_count;
  modport master (
    output we, waddr, wdata, raddr1, raddr2, busy_set, busy_addr,
    input  rdata1, rdata2, busy1, busy2, wr_count
  );
  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, busy_set, busy_addr,
    output rdata1, rdata2, busy1, busy2, wr_count
  );
endinterface

// File: rtl/regfile_scoreboard_bits.sv
// regfile_scoreboard_bits: per-register busy vector, set beats clear on the same address
module regfile_scoreboard_bits
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic              busy1,
  output logic              busy2
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DEPTH-1:0] bits_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q <= '0;
    end else begin
      if (clr) bits_q[clr_addr] <= 1'b0;
      if (set) bits_q[set_addr] <= 1'b1;
    end
  end
  assign busy1 = bits_q[addr1];
  assign busy2 = bits_q[addr2];
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with optional zero register, write bypass,
// RAW busy scoreboard and committed-write counter
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_scoreboard_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] Z = ADDR_W'(ZERO_ADDR);
  logic [DATA_W-1:0] regs [DEPTH];
  logic [31:0]       cnt_q;
  logic wr_en, set_en, byp1, byp2, z1, z2, sb1, sb2;
  assign wr_en  = bus.we && !(ZERO_REG != 0 && bus.waddr == Z);
  assign set_en = bus.busy_set && !(ZERO_REG != 0 && bus.busy_addr == Z);
  assign byp1   = BYPASS != 0 && wr_en && bus.waddr == bus.raddr1;
  assign byp2   = BYPASS != 0 && wr_en && bus.waddr == bus.raddr2;
  assign z1     = ZERO_REG != 0 && bus.raddr1 == Z;
  assign z2     = ZERO_REG != 0 && bus.raddr2 == Z;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      cnt_q <= '0;
    end else if (wr_en) begin
      regs[bus.waddr] <= bus.wdata;
      cnt_q <= cnt_q + 32'd1;
    end
  end
  regfile_scoreboard_bits #(.ADDR_W(ADDR_W)) u_bits (
    .clk      (clk),
    .rst_n    (rst_n),
    .set      (set_en),
    .set_addr (bus.busy_addr),
    .clr      (wr_en),
    .clr_addr (bus.waddr),
    .addr1    (bus.raddr1),
    .addr2    (bus.raddr2),
    .busy1    (sb1),
    .busy2    (sb2)
  );
  // a forwarded write already satisfies the hazard, so it hides the busy bit
  assign bus.rdata1   = z1 ? '0 : byp1 ? bus.wdata : regs[bus.raddr1];
  assign bus.rdata2   = z2 ? '0 : byp2 ? bus.wdata : regs[bus.raddr2];
  assign bus.busy1    = sb1 && !byp1;
  assign bus.busy2    = sb2 && !byp2;
  assign bus.wr_count = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors against a bypass/zero-reg instance (d1)
// and a plain instance without bypass or zero register (d0)
module tb_regfile_scoreboard;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  regfile_scoreboard_if b1 ();
  regfile_scoreboard_if b0 ();
  regfile_scoreboard #(.BYPASS(1), .ZERO_REG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  regfile_scoreboard #(.BYPASS(0), .ZERO_REG(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input reg_addr_t wa, input reg_data_t wd,
                       input reg_addr_t r1, input reg_addr_t r2,
                       input logic bs, input reg_addr_t ba);
    b1.we = we; b1.waddr = wa; b1.wdata = wd; b1.raddr1 = r1; b1.raddr2 = r2;
    b1.busy_set = bs; b1.busy_addr = ba;
    b0.we = we; b0.waddr = wa; b0.wdata = wd; b0.raddr1 = r1; b0.raddr2 = r2;
    b0.busy_set = bs; b0.busy_addr = ba;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    // activity before the mid-run reset
    drive(1, 3, 32'h11, 3, 6, 1, 6);
    tick;
    drive(0, 0, 0, 3, 6, 0, 0);
    chk("pre_rd_r3", b1.rdata1, 32'h11);
    chk("pre_busy_r6", {31'b0, b1.busy2}, 32'd1);
    drive(1, 4, 32'h55, 3, 4, 1, 8);
    rst_n = 1'b0;
    tick;
    drive(0, 0, 0, 3, 4, 0, 0);
    rst_n = 1'b1;
    chk("rst_rd1_r3", b1.rdata1, 0);
    chk("rst_rd2_r4", b1.rdata2, 0);
    chk("rst_d0_rd2_r4", b0.rdata2, 0);
    chk("rst_cnt", b1.wr_count, 0);
    chk("rst_d0_cnt", b0.wr_count, 0);
    drive(0, 0, 0, 6, 8, 0, 0);
    chk("rst_busy1_r6", {31'b0, b1.busy1}, 0);
    chk("rst_busy2_r8", {31'b0, b1.busy2}, 0);
    // plain write then read
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 5, 5, 0, 0);
    chk("wr_rd1_r5", b1.rdata1, 32'hDEADBEEF);
    chk("same_addr_rd2_r5", b1.rdata2, 32'hDEADBEEF);
    chk("d0_rd1_r5", b0.rdata1, 32'hDEADBEEF);
    chk("cnt_1", b1.wr_count, 1);
    // bypass on r7
    drive(1, 7, 32'hAAAA0007, 0, 0, 0, 0);
    tick;
    drive(1, 7, 32'h12345678, 0, 7, 0, 0);
    chk("byp_rd2_r7", b1.rdata2, 32'h12345678);
    chk("nobyp_rd2_r7", b0.rdata2, 32'hAAAA0007);
    tick;
    drive(0, 0, 0, 7, 0, 0, 0);
    chk("after_byp_r7", b1.rdata1, 32'h12345678);
    chk("d0_after_r7", b0.rdata1, 32'h12345678);
    chk("cnt_3", b1.wr_count, 3);
    // zero register (d0 has an ordinary r0)
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 1, 0);
    chk("zero_byp_rd1", b1.rdata1, 0);
    chk("d0_r0_old", b0.rdata1, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("zero_rd1", b1.rdata1, 0);
    chk("zero_busy1", {31'b0, b1.busy1}, 0);
    chk("zero_cnt", b1.wr_count, 3);
    chk("d0_r0_rd1", b0.rdata1, 32'hFFFFFFFF);
    chk("d0_r0_busy", {31'b0, b0.busy1}, 1);
    chk("d0_r0_cnt", b0.wr_count, 4);
    // scoreboard on r9
    drive(0, 0, 0, 0, 0, 1, 9);
    tick;
    drive(0, 0, 0, 9, 0, 0, 0);
    chk("sb_set_r9", {31'b0, b1.busy1}, 1);
    drive(1, 9, 32'h99, 9, 0, 1, 9);
    chk("sb_fwd_busy_r9", {31'b0, b1.busy1}, 0);
    chk("sb_fwd_data_r9", b1.rdata1, 32'h99);
    chk("d0_sb_nofwd_r9", {31'b0, b0.busy1}, 1);
    tick;
    drive(0, 0, 0, 9, 0, 0, 0);
    chk("sb_set_wins_r9", {31'b0, b1.busy1}, 1);
    chk("d0_set_wins_r9", {31'b0, b0.busy1}, 1);
    drive(1, 9, 32'h9A, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 9, 0, 0, 0);
    chk("sb_clr_r9", {31'b0, b1.busy1}, 0);
    // set and clear on different addresses in one cycle
    drive(0, 0, 0, 0, 0, 1, 11);
    tick;
    drive(1, 11, 32'hB, 0, 0, 1, 12);
    tick;
    drive(0, 0, 0, 11, 12, 0, 0);
    chk("sb_clr_r11", {31'b0, b1.busy1}, 0);
    chk("sb_set_r12", {31'b0, b1.busy2}, 1);
    chk("cnt_6", b1.wr_count, 6);
    chk("d0_cnt_7", b0.wr_count, 7);
    // counter wrap
    force dut1.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut1.cnt_q;
    drive(1, 13, 32'h1, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 13, 0, 0, 0);
    chk("cnt_wrap", b1.wr_count, 0);
    chk("wrap_rd_r13", b1.rdata1, 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
